// File: rtl/fofb_link_arbiter_if.sv
// fofb_link_arbiter_if
//   Bundle of all stream, suppress and statistics signals around the FOFB
//   link arbiter.
//   Parameter: DW - data width of all streams.
//   Modports:
//     slave  - arbiter view: consumes S00/S01 streams, suppress inputs and
//              M00 TREADY; drives source TREADYs, the M00 stream and counters.
//     master - environment view: drives the link FIFO streams, suppress
//              inputs and downstream ready; observes everything else.
interface fofb_link_arbiter_if #(
  parameter int DW = 8
);
  logic          S00_AXIS_TVALID;
  logic          S00_AXIS_TREADY;
  logic [DW-1:0] S00_AXIS_TDATA;
  logic          S00_AXIS_TLAST;
  logic          S00_ARB_REQ_SUPPRESS;

  logic          S01_AXIS_TVALID;
  logic          S01_AXIS_TREADY;
  logic [DW-1:0] S01_AXIS_TDATA;
  logic          S01_AXIS_TLAST;
  logic          S01_ARB_REQ_SUPPRESS;

  logic          M00_AXIS_TVALID;
  logic          M00_AXIS_TREADY;
  logic [DW-1:0] M00_AXIS_TDATA;
  logic          M00_AXIS_TLAST;
  logic          M00_AXIS_TID;

  logic [15:0]   PKT_COUNT_00;
  logic [15:0]   PKT_COUNT_01;
  logic [7:0]    ABORT_COUNT;

  modport slave (
    input  S00_AXIS_TVALID, S00_AXIS_TDATA, S00_AXIS_TLAST, S00_ARB_REQ_SUPPRESS,
    input  S01_AXIS_TVALID, S01_AXIS_TDATA, S01_AXIS_TLAST, S01_ARB_REQ_SUPPRESS,
    input  M00_AXIS_TREADY,
    output S00_AXIS_TREADY, S01_AXIS_TREADY,
    output M00_AXIS_TVALID, M00_AXIS_TDATA, M00_AXIS_TLAST, M00_AXIS_TID,
    output PKT_COUNT_00, PKT_COUNT_01, ABORT_COUNT
  );

  modport master (
    output S00_AXIS_TVALID, S00_AXIS_TDATA, S00_AXIS_TLAST, S00_ARB_REQ_SUPPRESS,
    output S01_AXIS_TVALID, S01_AXIS_TDATA, S01_AXIS_TLAST, S01_ARB_REQ_SUPPRESS,
    output M00_AXIS_TREADY,
    input  S00_AXIS_TREADY, S01_AXIS_TREADY,
    input  M00_AXIS_TVALID, M00_AXIS_TDATA, M00_AXIS_TLAST, M00_AXIS_TID,
    input  PKT_COUNT_00, PKT_COUNT_01, ABORT_COUNT
  );
endinterface

// File: rtl/fofb_link_arbiter.sv
// fofb_link_arbiter
//   Packet-granular round-robin arbiter sharing one AXI-Stream output between
//   the CCW (S00) and CW (S01) FOFB read-link FIFOs. Whole packets are granted,
//   runaway packets are truncated at MAX_PKT_WORDS (forced TLAST) and the rest
//   of the source packet is drained silently.
//   Ports:
//     ACLK   - sole clock, rising edge
//     ARESET - asynchronous active-high reset
//     bus    - fofb_link_arbiter_if.slave (S00/S01 streams + suppress,
//              M00 stream with TID, PKT_COUNT_00/01, ABORT_COUNT)
//   Build option: define FOFB_ARB_STATS_EN to implement the packet/abort
//   counters; otherwise they read as 0 and arbitration is unchanged.
//
//   state   | meaning
//   IDLE    | no grant; arbitrate between requesting sources
//   GRANT0  | S00 packet passes combinationally to M00
//   GRANT1  | S01 packet passes combinationally to M00
//   DRAIN0  | S00 packet truncated; discard words up to its TLAST
//   DRAIN1  | S01 packet truncated; discard words up to its TLAST
module fofb_link_arbiter #(
  parameter int DW            = 8,
  parameter int MAX_PKT_WORDS = 16
) (
  input logic                 ACLK,
  input logic                 ARESET,
  fofb_link_arbiter_if.slave  bus
);
  localparam int              WCW     = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [WCW-1:0]  WC_LAST = WCW'(MAX_PKT_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1,
    ST_DRAIN0,
    ST_DRAIN1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_last_grant, w_last_grant_nxt;
  logic [WCW-1:0] r_wc, w_wc_nxt;

  logic           w_req0, w_req1;
  logic           w_sel;
  logic           w_src_valid, w_src_last;
  logic [DW-1:0]  w_src_data;
  logic           w_wc_lim;

  logic           w_s00_ready, w_s01_ready;
  logic           w_m_valid, w_m_last, w_m_tid;
  logic [DW-1:0]  w_m_data;

  // Suppress only matters here because requests are looked at in IDLE only.
  assign w_req0 = bus.S00_AXIS_TVALID & ~bus.S00_ARB_REQ_SUPPRESS;
  assign w_req1 = bus.S01_AXIS_TVALID & ~bus.S01_ARB_REQ_SUPPRESS;

  // Source currently owning the grant/drain (don't care in IDLE).
  assign w_sel       = (r_state == ST_GRANT1) || (r_state == ST_DRAIN1);
  assign w_src_valid = w_sel ? bus.S01_AXIS_TVALID : bus.S00_AXIS_TVALID;
  assign w_src_last  = w_sel ? bus.S01_AXIS_TLAST  : bus.S00_AXIS_TLAST;
  assign w_src_data  = w_sel ? bus.S01_AXIS_TDATA  : bus.S00_AXIS_TDATA;
  assign w_wc_lim    = (r_wc == WC_LAST);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b0;
      r_wc         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wc         <= w_wc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_wc_nxt         = r_wc;
    w_s00_ready      = 1'b0;
    w_s01_ready      = 1'b0;
    w_m_valid        = 1'b0;
    w_m_data         = '0;
    w_m_last         = 1'b0;
    w_m_tid          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_wc_nxt = '0;
        if (w_req0 && w_req1) begin
          // Tie: favour the source that did not win last time.
          w_state_nxt      = r_last_grant ? ST_GRANT0 : ST_GRANT1;
          w_last_grant_nxt = ~r_last_grant;
        end else if (w_req0) begin
          w_state_nxt      = ST_GRANT0;
          w_last_grant_nxt = 1'b0;
        end else if (w_req1) begin
          w_state_nxt      = ST_GRANT1;
          w_last_grant_nxt = 1'b1;
        end
      end

      ST_GRANT0, ST_GRANT1: begin
        w_m_valid = w_src_valid;
        w_m_data  = w_src_data;
        w_m_tid   = w_sel;
        // The MAX_PKT_WORDS-th word always carries TLAST downstream.
        w_m_last  = w_src_last | w_wc_lim;
        if (w_sel) w_s01_ready = bus.M00_AXIS_TREADY;
        else       w_s00_ready = bus.M00_AXIS_TREADY;
        if (w_src_valid && bus.M00_AXIS_TREADY) begin
          w_wc_nxt = r_wc + 1'b1;
          if (w_src_last)    w_state_nxt = ST_IDLE;
          else if (w_wc_lim) w_state_nxt = w_sel ? ST_DRAIN1 : ST_DRAIN0;
        end
      end

      ST_DRAIN0, ST_DRAIN1: begin
        if (w_sel) w_s01_ready = 1'b1;
        else       w_s00_ready = 1'b1;
        if (w_src_valid && w_src_last) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.S00_AXIS_TREADY = w_s00_ready;
  assign bus.S01_AXIS_TREADY = w_s01_ready;
  assign bus.M00_AXIS_TVALID = w_m_valid;
  assign bus.M00_AXIS_TDATA  = w_m_data;
  assign bus.M00_AXIS_TLAST  = w_m_last;
  assign bus.M00_AXIS_TID    = w_m_tid;

`ifdef FOFB_ARB_STATS_EN
  logic        w_m_hs, w_done, w_abort;
  logic [15:0] r_pkt_cnt0, r_pkt_cnt1;
  logic [7:0]  r_abort_cnt;

  // w_m_valid is only ever high in GRANTx, so this is a granted handshake.
  assign w_m_hs  = w_m_valid & bus.M00_AXIS_TREADY;
  assign w_done  = w_m_hs & w_src_last;
  assign w_abort = w_m_hs & ~w_src_last & w_wc_lim;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_pkt_cnt0  <= '0;
      r_pkt_cnt1  <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_done && !w_sel) r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
      if (w_done &&  w_sel) r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
      if (w_abort && (r_abort_cnt != 8'hFF)) r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign bus.PKT_COUNT_00 = r_pkt_cnt0;
  assign bus.PKT_COUNT_01 = r_pkt_cnt1;
  assign bus.ABORT_COUNT  = r_abort_cnt;
`else
  assign bus.PKT_COUNT_00 = '0;
  assign bus.PKT_COUNT_01 = '0;
  assign bus.ABORT_COUNT  = '0;
`endif

endmodule

// File: tb/tb_fofb_link_arbiter.sv
// tb_fofb_link_arbiter
//   Directed bench for fofb_link_arbiter. Source FIFOs are modelled as word
//   queues ({tlast, data}); every M00 handshake is captured with its cycle
//   index and checked against hand-derived expectations.
module tb_fofb_link_arbiter;
  localparam int DW   = 8;
  localparam int MAXW = 16;
`ifdef FOFB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       tid;
    logic       last;
    logic [7:0] data;
    int         cyc;
  } cap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fofb_link_arbiter_if #(.DW(DW)) bus();

  fofb_link_arbiter #(.DW(DW), .MAX_PKT_WORDS(MAXW)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  cap_t       caps[$];
  logic       sup0, sup1, m_rdy;
  int         cyc;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [8:0] wd(input logic last, input logic [7:0] d);
    return {last, d};
  endfunction

  task automatic drive();
    bus.S00_ARB_REQ_SUPPRESS = sup0;
    bus.S01_ARB_REQ_SUPPRESS = sup1;
    bus.M00_AXIS_TREADY      = m_rdy;
    bus.S00_AXIS_TVALID = 1'b0; bus.S00_AXIS_TDATA = 8'h00; bus.S00_AXIS_TLAST = 1'b0;
    bus.S01_AXIS_TVALID = 1'b0; bus.S01_AXIS_TDATA = 8'h00; bus.S01_AXIS_TLAST = 1'b0;
    if (q0.size() > 0) begin
      bus.S00_AXIS_TVALID = 1'b1; bus.S00_AXIS_TDATA = q0[0][7:0]; bus.S00_AXIS_TLAST = q0[0][8];
    end
    if (q1.size() > 0) begin
      bus.S01_AXIS_TVALID = 1'b1; bus.S01_AXIS_TDATA = q1[0][7:0]; bus.S01_AXIS_TLAST = q1[0][8];
    end
  endtask

  // One clock: sample handshakes at the falling edge, advance the sources
  // just after the rising edge.
  task automatic tick();
    bit   h0, h1;
    cap_t c;
    @(negedge clk);
    h0 = bus.S00_AXIS_TVALID && bus.S00_AXIS_TREADY;
    h1 = bus.S01_AXIS_TVALID && bus.S01_AXIS_TREADY;
    if (bus.M00_AXIS_TVALID && bus.M00_AXIS_TREADY) begin
      c.tid = bus.M00_AXIS_TID; c.last = bus.M00_AXIS_TLAST;
      c.data = bus.M00_AXIS_TDATA; c.cyc = cyc;
      caps.push_back(c);
    end
    @(posedge clk);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    cyc++;
    drive();
  endtask

  // which: 0 = until q0 empty, 1 = until q1 empty, 2 = until both empty.
  task automatic run(input int which, input int max, output bit to);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < max) begin
      tick();
      n++;
      case (which)
        0:       done = (q0.size() == 0);
        1:       done = (q1.size() == 0);
        default: done = (q0.size() == 0) && (q1.size() == 0);
      endcase
    end
    to = !done;
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); caps.delete();
    sup0 = 1'b0; sup1 = 1'b0; m_rdy = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sup0 = 1'b0; sup1 = 1'b0; m_rdy = 1'b1;
    q0.delete(); q1.delete();
    q0.push_back(wd(1'b1, 8'h5A));
    q1.push_back(wd(1'b1, 8'hA5));
    drive();
    @(posedge clk);
    #2;
    n_vec++;
    if ({bus.S00_AXIS_TREADY, bus.S01_AXIS_TREADY, bus.M00_AXIS_TVALID,
         bus.M00_AXIS_TLAST, bus.M00_AXIS_TID} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b required 00000", {bus.S00_AXIS_TREADY,
               bus.S01_AXIS_TREADY, bus.M00_AXIS_TVALID, bus.M00_AXIS_TLAST, bus.M00_AXIS_TID});
    end
    n_vec++;
    if (bus.M00_AXIS_TDATA !== 8'h00) begin
      n_err++;
      $display("FAIL reset_tdata got %h required 00", bus.M00_AXIS_TDATA);
    end
    n_vec++;
    if ({bus.PKT_COUNT_00, bus.PKT_COUNT_01, bus.ABORT_COUNT} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_counts got %h/%h/%h required 0/0/0",
               bus.PKT_COUNT_00, bus.PKT_COUNT_01, bus.ABORT_COUNT);
    end
    do_reset();
  endtask

  task automatic test_single_pkt();
    bit to;
    do_reset();
    for (int i = 0; i < 3; i++) q0.push_back(wd(i == 2, 8'hA1 + 8'(i)));
    drive();
    #1;
    n_vec++;
    if ({bus.M00_AXIS_TVALID, bus.S00_AXIS_TREADY} !== 2'b00 || bus.M00_AXIS_TDATA !== 8'h00) begin
      n_err++;
      $display("FAIL idle_outputs got v=%b r=%b d=%h required 0 0 00",
               bus.M00_AXIS_TVALID, bus.S00_AXIS_TREADY, bus.M00_AXIS_TDATA);
    end
    run(0, 20, to);
    n_vec++;
    if (to || caps.size() != 3) begin
      n_err++;
      $display("FAIL single_count got %0d words timeout=%0d required 3", caps.size(), to);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if ({caps[i].tid, caps[i].last, caps[i].data} !== {1'b0, (i == 2), 8'hA1 + 8'(i)}
            || caps[i].cyc != 1 + i) begin
          n_err++;
          $display("FAIL single_word%0d got tid=%b last=%b d=%h cyc=%0d required 0 %0d %h %0d",
                   i, caps[i].tid, caps[i].last, caps[i].data, caps[i].cyc,
                   (i == 2), 8'hA1 + 8'(i), 1 + i);
        end
      end
    end
    n_vec++;
    if (bus.PKT_COUNT_00 !== (STATS ? 16'd1 : 16'd0) || bus.PKT_COUNT_01 !== 16'd0) begin
      n_err++;
      $display("FAIL single_pktcnt got %0d/%0d required %0d/0",
               bus.PKT_COUNT_00, bus.PKT_COUNT_01, STATS ? 1 : 0);
    end
  endtask

  task automatic test_alternate();
    bit to;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int w = 0; w < 4; w++) begin
        q0.push_back(wd(w == 3, {1'b0, 3'(p), 4'(w)}));
        q1.push_back(wd(w == 3, {1'b1, 3'(p), 4'(w)}));
      end
    end
    drive();
    run(2, 200, to);
    n_vec++;
    if (to || caps.size() != 40) begin
      n_err++;
      $display("FAIL alt_count got %0d words timeout=%0d required 40", caps.size(), to);
    end else begin
      for (int i = 0; i < 40; i++) begin
        int         k, w, ecyc;
        logic       src;
        logic [7:0] ed;
        k = i / 4; w = i % 4;
        src = (k % 2 == 0);
        ed = {src, 3'(k / 2), 4'(w)};
        ecyc = 1 + k * 5 + w;
        n_vec++;
        if ({caps[i].tid, caps[i].last, caps[i].data} !== {src, (w == 3), ed} || caps[i].cyc != ecyc) begin
          n_err++;
          $display("FAIL alt_word%0d got tid=%b last=%b d=%h cyc=%0d required %b %0d %h %0d",
                   i, caps[i].tid, caps[i].last, caps[i].data, caps[i].cyc, src, (w == 3), ed, ecyc);
        end
      end
    end
    n_vec++;
    if (bus.PKT_COUNT_00 !== (STATS ? 16'd5 : 16'd0) || bus.PKT_COUNT_01 !== (STATS ? 16'd5 : 16'd0)) begin
      n_err++;
      $display("FAIL alt_pktcnt got %0d/%0d required %0d/%0d",
               bus.PKT_COUNT_00, bus.PKT_COUNT_01, STATS ? 5 : 0, STATS ? 5 : 0);
    end
  endtask

  task automatic test_suppress();
    bit to;
    int base;
    do_reset();
    sup1 = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(wd(i % 2 == 1, 8'h10 + 8'(i)));
    q1.push_back(wd(1'b0, 8'h90));
    q1.push_back(wd(1'b1, 8'h91));
    drive();
    run(0, 50, to);
    n_vec++;
    if (to || caps.size() != 4 || q1.size() != 2) begin
      n_err++;
      $display("FAIL sup_only_s00 got %0d words, s01 left %0d required 4, 2", caps.size(), q1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (caps[i].tid !== 1'b0 || caps[i].data !== 8'h10 + 8'(i)) begin
          n_err++;
          $display("FAIL sup_word%0d got tid=%b d=%h required 0 %h",
                   i, caps[i].tid, caps[i].data, 8'h10 + 8'(i));
        end
      end
    end
    caps.delete();
    sup1 = 1'b0;
    drive();
    base = cyc;
    run(1, 50, to);
    n_vec++;
    if (to || caps.size() != 2) begin
      n_err++;
      $display("FAIL unsup_count got %0d words required 2", caps.size());
    end else begin
      n_vec++;
      if (caps[0].tid !== 1'b1 || caps[0].data !== 8'h90 || caps[0].cyc != base + 1) begin
        n_err++;
        $display("FAIL unsup_first got tid=%b d=%h cyc=%0d required 1 90 %0d",
                 caps[0].tid, caps[0].data, caps[0].cyc, base + 1);
      end
    end
    caps.delete();
    for (int i = 0; i < 4; i++) q1.push_back(wd(i == 3, 8'hA0 + 8'(i)));
    drive();
    tick();
    tick();
    sup1 = 1'b1;
    drive();
    run(1, 50, to);
    n_vec++;
    if (to || caps.size() != 4) begin
      n_err++;
      $display("FAIL midsup_count got %0d words required 4", caps.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if ({caps[i].tid, caps[i].last, caps[i].data} !== {1'b1, (i == 3), 8'hA0 + 8'(i)}) begin
          n_err++;
          $display("FAIL midsup_word%0d got tid=%b last=%b d=%h required 1 %0d %h",
                   i, caps[i].tid, caps[i].last, caps[i].data, (i == 3), 8'hA0 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_truncate();
    bit to;
    do_reset();
    for (int i = 0; i < 20; i++) q0.push_back(wd(1'b0, 8'(i + 1)));
    drive();
    run(0, 100, to);
    n_vec++;
    if (to || caps.size() != 16) begin
      n_err++;
      $display("FAIL trunc_count got %0d words timeout=%0d required 16", caps.size(), to);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_vec++;
        if ({caps[i].tid, caps[i].last, caps[i].data} !== {1'b0, (i == 15), 8'(i + 1)}) begin
          n_err++;
          $display("FAIL trunc_word%0d got tid=%b last=%b d=%h required 0 %0d %h",
                   i, caps[i].tid, caps[i].last, caps[i].data, (i == 15), 8'(i + 1));
        end
      end
    end
    n_vec++;
    if (bus.ABORT_COUNT !== (STATS ? 8'd1 : 8'd0) || bus.PKT_COUNT_00 !== 16'd0) begin
      n_err++;
      $display("FAIL trunc_counts got abort=%0d pkt=%0d required %0d 0",
               bus.ABORT_COUNT, bus.PKT_COUNT_00, STATS ? 1 : 0);
    end
    q0.push_back(wd(1'b1, 8'hEE));
    drive();
    run(0, 20, to);
    n_vec++;
    if (to || caps.size() != 16 || bus.PKT_COUNT_00 !== 16'd0) begin
      n_err++;
      $display("FAIL drain_end got %0d words pkt=%0d required 16 0", caps.size(), bus.PKT_COUNT_00);
    end
    q0.push_back(wd(1'b1, 8'h55));
    for (int i = 0; i < 16; i++) q0.push_back(wd(i == 15, 8'hC0 + 8'(i)));
    drive();
    run(0, 100, to);
    n_vec++;
    if (to || caps.size() != 33) begin
      n_err++;
      $display("FAIL post_drain_count got %0d words required 33", caps.size());
    end else begin
      n_vec++;
      if ({caps[16].tid, caps[16].last, caps[16].data} !== {1'b0, 1'b1, 8'h55}) begin
        n_err++;
        $display("FAIL post_drain_word got tid=%b last=%b d=%h required 0 1 55",
                 caps[16].tid, caps[16].last, caps[16].data);
      end
      n_vec++;
      if ({caps[31].last, caps[32].last, caps[32].data} !== {1'b0, 1'b1, 8'hCF}) begin
        n_err++;
        $display("FAIL exact_max_tail got last15=%b last16=%b d=%h required 0 1 cf",
                 caps[31].last, caps[32].last, caps[32].data);
      end
    end
    n_vec++;
    if (bus.PKT_COUNT_00 !== (STATS ? 16'd2 : 16'd0) || bus.ABORT_COUNT !== (STATS ? 8'd1 : 8'd0)) begin
      n_err++;
      $display("FAIL exact_max_counts got pkt=%0d abort=%0d required %0d %0d",
               bus.PKT_COUNT_00, bus.ABORT_COUNT, STATS ? 2 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    m_rdy = 1'b0;
    for (int i = 0; i < 5; i++) q0.push_back(wd(i == 4, 8'h30 + 8'(i)));
    drive();
    while (q0.size() > 0 && n < 40) begin
      m_rdy = ~m_rdy;
      drive();
      #1;
      if (bus.M00_AXIS_TVALID) begin
        n_vec++;
        if (bus.S00_AXIS_TREADY !== m_rdy || bus.S01_AXIS_TREADY !== 1'b0) begin
          n_err++;
          $display("FAIL bp_mirror got s00_ready=%b s01_ready=%b required %b 0",
                   bus.S00_AXIS_TREADY, bus.S01_AXIS_TREADY, m_rdy);
        end
      end
      tick();
      n++;
    end
    m_rdy = 1'b1;
    drive();
    repeat (2) tick();
    n_vec++;
    if (q0.size() != 0 || caps.size() != 5) begin
      n_err++;
      $display("FAIL bp_count got %0d words, %0d left required 5, 0", caps.size(), q0.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if ({caps[i].tid, caps[i].last, caps[i].data} !== {1'b0, (i == 4), 8'h30 + 8'(i)}) begin
          n_err++;
          $display("FAIL bp_word%0d got tid=%b last=%b d=%h required 0 %0d %h",
                   i, caps[i].tid, caps[i].last, caps[i].data, (i == 4), 8'h30 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    q1.push_back(wd(1'b1, 8'hC1));
    drive();
    run(1, 20, to);
    for (int i = 0; i < 5; i++) q0.push_back(wd(i == 4, 8'h40 + 8'(i)));
    drive();
    tick();
    tick();
    #1;
    n_vec++;
    if (bus.M00_AXIS_TVALID !== 1'b1 || bus.M00_AXIS_TDATA !== 8'h41 || bus.PKT_COUNT_01 !== (STATS ? 16'd1 : 16'd0)) begin
      n_err++;
      $display("FAIL prereset got v=%b d=%h pkt01=%0d required 1 41 %0d",
               bus.M00_AXIS_TVALID, bus.M00_AXIS_TDATA, bus.PKT_COUNT_01, STATS ? 1 : 0);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.S00_AXIS_TREADY, bus.S01_AXIS_TREADY, bus.M00_AXIS_TVALID, bus.M00_AXIS_TLAST,
         bus.M00_AXIS_TID, bus.M00_AXIS_TDATA} !== 13'h0
        || {bus.PKT_COUNT_00, bus.PKT_COUNT_01, bus.ABORT_COUNT} !== 40'h0) begin
      n_err++;
      $display("FAIL async_reset got ctrl=%b d=%h cnt=%h/%h/%h required all 0",
               {bus.S00_AXIS_TREADY, bus.S01_AXIS_TREADY, bus.M00_AXIS_TVALID, bus.M00_AXIS_TLAST,
                bus.M00_AXIS_TID}, bus.M00_AXIS_TDATA, bus.PKT_COUNT_00, bus.PKT_COUNT_01, bus.ABORT_COUNT);
    end
    q0.delete(); q1.delete(); caps.delete();
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    q0.push_back(wd(1'b1, 8'h61));
    q1.push_back(wd(1'b1, 8'h71));
    drive();
    run(2, 20, to);
    n_vec++;
    if (to || caps.size() != 2) begin
      n_err++;
      $display("FAIL post_reset_count got %0d words required 2", caps.size());
    end else begin
      n_vec++;
      if ({caps[0].tid, caps[0].data} !== {1'b1, 8'h71} || caps[0].cyc != 1
          || {caps[1].tid, caps[1].data} !== {1'b0, 8'h61} || caps[1].cyc != 3) begin
        n_err++;
        $display("FAIL post_reset_order got %b:%h@%0d %b:%h@%0d required 1:71@1 0:61@3",
                 caps[0].tid, caps[0].data, caps[0].cyc, caps[1].tid, caps[1].data, caps[1].cyc);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    test_reset();
    test_single_pkt();
    test_alternate();
    test_suppress();
    test_truncate();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fofb_link_arbiter.md
# fofb_link_arbiter

Packet-granular round-robin arbiter sharing one AXI-Stream output between the two FOFB read-link sources (CCW/CW link FIFOs). Grants whole packets, never interleaves words of two packets, honours per-source request suppression, and truncates/drains runaway packets that exceed a maximum length. Sits between the per-link receive FIFOs and the FOFB packet decoder, replacing the free-running empty-toggle selection.

## Interface
- DW, 8, data width of all streams
- MAX_PKT_WORDS, 16, maximum words per packet (≥2); word counter width WCW = $clog2(MAX_PKT_WORDS+1)

- ACLK  in  1  sole clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- S00_AXIS_TVALID / S01_AXIS_TVALID  in  1  source word valid
- S00_AXIS_TREADY / S01_AXIS_TREADY  out  1  source word accepted
- S00_AXIS_TDATA / S01_AXIS_TDATA  in  DW  source data
- S00_AXIS_TLAST / S01_AXIS_TLAST  in  1  last word of packet
- S00_ARB_REQ_SUPPRESS / S01_ARB_REQ_SUPPRESS  in  1  block new grants to that source
- M00_AXIS_TVALID  out  1  output valid
- M00_AXIS_TREADY  in  1  output ready
- M00_AXIS_TDATA  out  DW  output data
- M00_AXIS_TLAST  out  1  output last (source TLAST or forced)
- M00_AXIS_TID  out  1  source of current packet (0 = S00)
- PKT_COUNT_00 / PKT_COUNT_01  out  16  completed packets per source
- ABORT_COUNT  out  8  truncated packets

## Operation
- States: IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1. Register last_grant (reset 0 → S01 favoured first on tie).
- Request: reqN = SNN_AXIS_TVALID & ~SNN_ARB_REQ_SUPPRESS.
- IDLE: all TREADY=0, M00_AXIS_TVALID=0. One request → GRANT of it; both → GRANT of source ≠ last_grant; none → stay. last_grant updates on entry to GRANTx.
- GRANTx: combinational pass-through: M00_AXIS_TVALID=SxTVALID, M00_AXIS_TDATA=SxTDATA, SxTREADY=M00_AXIS_TREADY, other source TREADY=0, M00_AXIS_TID=x.
- Word counter wc (WCW bits) clears on entry to GRANTx, increments per output handshake (TVALID&TREADY).
- Handshake with TLAST=1 → IDLE, PKT_COUNT_x += 1 (wraps at 2^16).
- Handshake with TLAST=0 and wc==MAX_PKT_WORDS-1: M00_AXIS_TLAST forced 1 on that word, ABORT_COUNT += 1 (saturates 255), → DRAINx.
- DRAINx: SxTREADY=1, M00_AXIS_TVALID=0; discard words; handshake with TLAST → IDLE (no PKT_COUNT increment).
- Suppress inputs sampled only in IDLE; assertion mid-packet has no effect on the current packet.
- Source TVALID deasserting mid-packet: grant held, M00_AXIS_TVALID follows, no timeout.

## Timing
- Reset values: state IDLE, all TREADY 0, M00_AXIS_TVALID/TLAST/TID 0, M00_AXIS_TDATA 0 (driven 0 in IDLE/DRAIN), counters 0, last_grant 0.
- Arbitration latency: request visible in IDLE at edge k → first word transferable in cycle k+1.
- Data latency in GRANT: 0 cycles (combinational S→M), no buffering.
- One-cycle IDLE bubble between consecutive packets, including same-source back-to-back.
- Single-word packet (TLAST on first word): legal, counts as complete.
- ARESET asserted mid-packet: immediate return to reset values; partial packet on M00 is not terminated; downstream decoder resynchronises on next TLAST.
- Counter increments and state change occur on the same edge as the qualifying handshake.

## Configuration
- FOFB_ARB_STATS_EN defined: PKT_COUNT_00/01 and ABORT_COUNT registers implemented as above.
- Not defined: counters not synthesised, outputs tied to 0; arbitration, truncation and drain behaviour unchanged.

## Test plan
- Both sources idle then S00 sends 3-word packet, M00_AXIS_TREADY=1 → granted next cycle, M00 carries 3 words TID=0, TLAST on word 3, PKT_COUNT_00=1.
- Both sources hold 4-word packets continuously → grants alternate S01,S00,S01,… with one idle cycle between packets; no word interleaving; counts equal after 10 packets.
- S01_ARB_REQ_SUPPRESS=1 with both requesting → only S00 granted; deassert → S01 granted at next IDLE; suppress raised during S01 packet → packet completes.
- S00 sends 20 words without TLAST, MAX_PKT_WORDS=16 → M00 word 16 has forced TLAST, words 17–20 consumed with M00_AXIS_TVALID=0, ABORT_COUNT=1, PKT_COUNT_00 unchanged.
- M00_AXIS_TREADY toggled 1/0 each cycle during 5-word packet → S00_AXIS_TREADY mirrors it, all 5 words delivered in order, no duplicates.
- ARESET pulsed at word 2 of a granted packet → all outputs/counters return to 0 asynchronously; next request arbitrated normally after release.
